// File: rtl/npu_pkg.sv
`default_nettype none
// =====================================================================
// Module   : npu_pkg
// Brief    : Loader state encoding and layer-geometry helpers shared
//            with the NPU core top.
// Revision : 1.0 - initial release
// =====================================================================
package npu_pkg;

  localparam int c_MAX_LAYERS = 16;
  localparam int c_SIZES_W    = 8 * c_MAX_LAYERS;

  typedef logic [2:0] loader_state_e;

  localparam loader_state_e c_ST_IDLE   = 3'd0;
  localparam loader_state_e c_ST_LOAD_W = 3'd1;
  localparam loader_state_e c_ST_LOAD_B = 3'd2;
  localparam loader_state_e c_ST_CHECK  = 3'd3;
  localparam loader_state_e c_ST_DONE   = 3'd4;
  localparam loader_state_e c_ST_ERROR  = 3'd5;

  // Layer 0 lives in the most significant byte of the packed size vector.
  function automatic int get_layer_size(input logic [c_SIZES_W-1:0] sizes,
                                        input int num_layers, input int idx);
    logic [7:0] sz;
    sz = sizes[(num_layers-1-idx)*8 +: 8];
    return {24'd0, sz};
  endfunction

  function automatic int calc_w_words(input logic [c_SIZES_W-1:0] sizes,
                                      input int num_layers);
    int total;
    total = 0;
    for (int j = 1; j < num_layers; j++)
      total += get_layer_size(sizes, num_layers, j) * get_layer_size(sizes, num_layers, j-1);
    return total;
  endfunction

  function automatic int calc_b_words(input logic [c_SIZES_W-1:0] sizes,
                                      input int num_layers);
    int total;
    total = 0;
    for (int j = 1; j < num_layers; j++)
      total += get_layer_size(sizes, num_layers, j);
    return total;
  endfunction

  function automatic int calc_weights_bits(input logic [c_SIZES_W-1:0] sizes,
                                           input int num_layers, input int dw);
    return calc_w_words(sizes, num_layers) * dw;
  endfunction

  function automatic int calc_biases_bits(input logic [c_SIZES_W-1:0] sizes,
                                          input int num_layers, input int dw);
    return calc_b_words(sizes, num_layers) * dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/npu_stream_checksum.sv
`default_nettype none
// =====================================================================
// Module   : npu_stream_checksum
// Brief    : Modulo-2^DW running sum of stream beats, compared against a
//            captured reference word.
// Revision : 1.0 - initial release
// =====================================================================
module npu_stream_checksum #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  acc_en,
  input  logic                  ref_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  match
);

  logic [DATA_WIDTH-1:0] r_sum;
  logic [DATA_WIDTH-1:0] r_ref;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_ref <= '0;
    end else if (clear) begin
      r_sum <= '0;
      r_ref <= '0;
    end else begin
      if (acc_en) r_sum <= r_sum + data;
      if (ref_en) r_ref <= data;
    end
  end

  assign match = (r_sum == r_ref);

endmodule
`default_nettype wire

// File: rtl/npu_param_loader.sv
`default_nettype none
// =====================================================================
// Module   : npu_param_loader
// Brief    : Packs a valid/ready word stream into flat weight/bias
//            registers for the NPU core. Option: PARAM_CHECKSUM_EN.
// Revision : 1.0 - initial release
// =====================================================================
module npu_param_loader
  import npu_pkg::*;
#(
  parameter int                      NUM_LAYERS  = 3,
  parameter logic [8*NUM_LAYERS-1:0] LAYER_SIZES = 24'h04_08_04,
  parameter int                      DATA_WIDTH  = 8,
  localparam int c_W_WORDS = calc_w_words(c_SIZES_W'(LAYER_SIZES), NUM_LAYERS),
  localparam int c_B_WORDS = calc_b_words(c_SIZES_W'(LAYER_SIZES), NUM_LAYERS),
  localparam int c_W_BITS  = calc_weights_bits(c_SIZES_W'(LAYER_SIZES), NUM_LAYERS, DATA_WIDTH),
  localparam int c_B_BITS  = calc_biases_bits(c_SIZES_W'(LAYER_SIZES), NUM_LAYERS, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [c_W_BITS-1:0]   weights_flat,
  output logic [c_B_BITS-1:0]   biases_flat,
  output logic                  params_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int c_T_WORDS = c_W_WORDS + c_B_WORDS;
  localparam int c_CNT_W   = $clog2(c_T_WORDS + 1);
`ifdef PARAM_CHECKSUM_EN
  localparam int c_LAST_IDX = c_T_WORDS;
`else
  localparam int c_LAST_IDX = c_T_WORDS - 1;
`endif
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_LAST_IDX);
  localparam logic [c_CNT_W-1:0] c_CNT_W_END = c_CNT_W'(c_W_WORDS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  loader_state_e        r_state;
  loader_state_e        w_state_next;
  logic [c_CNT_W-1:0]   r_word_cnt;
  logic [c_W_BITS-1:0]  r_weights;
  logic [c_B_BITS-1:0]  r_biases;
  logic                 w_idle_like;
  logic                 w_load_start;
  logic                 w_accept;
  logic                 w_final_beat;
  logic                 w_framing_err;
  logic                 w_wr_weight;
  logic                 w_wr_bias;

  assign w_idle_like   = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE) ||
                         (r_state == c_ST_ERROR);
  assign w_load_start  = start && w_idle_like;
  assign w_accept      = s_valid && s_ready;
  assign w_final_beat  = (r_word_cnt == c_CNT_LAST);
  // s_last must appear on exactly the final expected beat.
  assign w_framing_err = (s_last != w_final_beat);
  assign w_wr_weight   = w_accept && (r_state == c_ST_LOAD_W);
  assign w_wr_bias     = w_accept && (r_state == c_ST_LOAD_B);

`ifdef PARAM_CHECKSUM_EN
  logic w_sum_match;
  logic w_sum_acc;
  logic w_sum_ref;

  assign w_sum_acc = w_accept && (r_word_cnt < c_CNT_W'(c_T_WORDS));
  assign w_sum_ref = w_accept && w_final_beat;

  npu_stream_checksum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_load_start),
    .acc_en (w_sum_acc),
    .ref_en (w_sum_ref),
    .data   (s_data),
    .match  (w_sum_match)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_DONE, c_ST_ERROR: begin
        if (start) w_state_next = c_ST_LOAD_W;
      end
      c_ST_LOAD_W, c_ST_LOAD_B: begin
        if (w_accept) begin
          if (w_framing_err)
            w_state_next = c_ST_ERROR;
          else if (w_final_beat)
`ifdef PARAM_CHECKSUM_EN
            w_state_next = c_ST_CHECK;
`else
            w_state_next = c_ST_DONE;
`endif
          else if ((r_state == c_ST_LOAD_W) && (r_word_cnt == c_CNT_W_END))
            w_state_next = c_ST_LOAD_B;
        end
      end
`ifdef PARAM_CHECKSUM_EN
      c_ST_CHECK: w_state_next = w_sum_match ? c_ST_DONE : c_ST_ERROR;
`endif
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready      = 1'b0;
    busy         = 1'b0;
    params_valid = 1'b0;
    err          = 1'b0;
    case (r_state)
      c_ST_LOAD_W, c_ST_LOAD_B: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      c_ST_CHECK: busy         = 1'b1;
      c_ST_DONE:  params_valid = 1'b1;
      c_ST_ERROR: err          = 1'b1;
      default: ;
    endcase
  end

  // One counter spans the whole stream; biases start at index c_W_WORDS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_word_cnt <= '0;
    else if (w_load_start) r_word_cnt <= '0;
    else if (w_accept)     r_word_cnt <= r_word_cnt + c_CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weights <= '0;
    end else if (w_wr_weight) begin
      for (int k = 0; k < c_W_WORDS; k++)
        if (r_word_cnt == c_CNT_W'(k))
          r_weights[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_biases <= '0;
    end else if (w_wr_bias) begin
      for (int k = 0; k < c_B_WORDS; k++)
        if (r_word_cnt == c_CNT_W'(c_W_WORDS + k))
          r_biases[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
    end
  end

  assign weights_flat = r_weights;
  assign biases_flat  = r_biases;

endmodule
`default_nettype wire

// File: tb/tb_npu_param_loader.sv
`default_nettype none
// =====================================================================
// Module   : tb_npu_param_loader
// Brief    : Self-checking bench for npu_param_loader, layers {4,8,4}, DW=8.
// Revision : 1.0 - initial release
// =====================================================================
module tb_npu_param_loader;

  localparam int DW      = 8;
  localparam int W_WORDS = 8*4 + 4*8;
  localparam int B_WORDS = 8 + 4;
  localparam int T_WORDS = W_WORDS + B_WORDS;
`ifdef PARAM_CHECKSUM_EN
  localparam int N_BEATS = T_WORDS + 1;
`else
  localparam int N_BEATS = T_WORDS;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_last = 1'b0;
  logic [DW-1:0]           s_data = '0;
  logic                    s_ready;
  logic [W_WORDS*DW-1:0]   weights_flat;
  logic [B_WORDS*DW-1:0]   biases_flat;
  logic                    params_valid;
  logic                    busy;
  logic                    err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference image of what the loader should hold.
  logic [DW-1:0] m_w [W_WORDS];
  logic [DW-1:0] m_b [B_WORDS];
  logic [DW-1:0] beats [$];

  npu_param_loader #(
    .NUM_LAYERS  (3),
    .LAYER_SIZES (24'h04_08_04),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .weights_flat (weights_flat),
    .biases_flat  (biases_flat),
    .params_valid (params_valid),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W_WORDS*DW-1:0] exp_w();
    logic [W_WORDS*DW-1:0] v;
    for (int k = 0; k < W_WORDS; k++) v[k*DW +: DW] = m_w[k];
    return v;
  endfunction

  function automatic logic [B_WORDS*DW-1:0] exp_b();
    logic [B_WORDS*DW-1:0] v;
    for (int k = 0; k < B_WORDS; k++) v[k*DW +: DW] = m_b[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < W_WORDS; k++) m_w[k] = '0;
    for (int k = 0; k < B_WORDS; k++) m_b[k] = '0;
  endtask

  task automatic mk_beats(input bit ramp);
    int sum;
    logic [DW-1:0] d;
    sum = 0;
    beats.delete();
    for (int k = 0; k < T_WORDS; k++) begin
      d = ramp ? DW'(k) : DW'($urandom);
      beats.push_back(d);
      sum += int'(d);
    end
`ifdef PARAM_CHECKSUM_EN
    beats.push_back(DW'(sum));
`endif
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Streams beats[0..n-1]; s_last on index last_at. Optional idle gaps and
  // stray start pulses (forced high on the final beat).
  task automatic send(input int n, input int last_at, input bit gaps, input bit poke);
    int budget;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          if (poke) start = 1'($urandom);
        end
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = beats[i];
      s_last  = (i == last_at);
      if (poke) begin
        start = (i == n-1) ? 1'b1 : 1'($urandom);
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_during_load beat %0d: got %b required 1", i, busy);
        end
      end
      budget = 0;
      while (s_ready !== 1'b1 && budget < 16) begin
        @(negedge clk);
        budget++;
      end
      if (s_ready !== 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout beat %0d: s_ready=%b required 1", i, s_ready);
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (i < W_WORDS) m_w[i] = beats[i];
      else if (i < T_WORDS) m_b[i-W_WORDS] = beats[i];
      s_valid = 1'b0;
      s_last  = 1'b0;
      start   = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({s_ready, busy, params_valid, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000", {s_ready, busy, params_valid, err});
    end
    n_tests++;
    if (weights_flat !== '0 || biases_flat !== '0) begin
      n_fail++;
      $display("FAIL reset_flat: got w=%h b=%h required 0", weights_flat, biases_flat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    // Partial load, then reset mid-stream.
    do_start();
    mk_beats(1'b1);
    send(10, -1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({s_ready, busy, params_valid, err} !== 4'b0000 || weights_flat !== '0) begin
      n_fail++;
      $display("FAIL reset_midload: flags=%b w=%h required all 0",
               {s_ready, busy, params_valid, err}, weights_flat);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_load();
    do_start();
    n_tests++;
    if (params_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_start: pv=%b busy=%b required pv=0 busy=1", params_valid, busy);
    end
    mk_beats(1'b1);
    send(N_BEATS, N_BEATS-1, 1'b0, 1'b0);
`ifdef PARAM_CHECKSUM_EN
    @(posedge clk);
    #1;
`endif
    n_tests++;
    if ({params_valid, busy, s_ready, err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL ramp_done_flags: pv/busy/rdy/err=%b required 1000",
               {params_valid, busy, s_ready, err});
    end
    n_tests++;
    if (weights_flat[7:0] !== 8'h00 || weights_flat[511:504] !== 8'h3F || biases_flat[95:88] !== 8'h4B) begin
      n_fail++;
      $display("FAIL ramp_bytes: got %h %h %h required 00 3f 4b",
               weights_flat[7:0], weights_flat[511:504], biases_flat[95:88]);
    end
    n_tests++;
    if (weights_flat !== exp_w() || biases_flat !== exp_b()) begin
      n_fail++;
      $display("FAIL ramp_image: got w=%h b=%h required w=%h b=%h",
               weights_flat[63:0], biases_flat, exp_w()[63:0], exp_b());
    end
  endtask

  task automatic test_gaps_and_start();
    do_start();
    mk_beats(1'b1);
    send(N_BEATS, N_BEATS-1, 1'b1, 1'b1);
`ifdef PARAM_CHECKSUM_EN
    @(posedge clk);
    #1;
`endif
    n_tests++;
    if (params_valid !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_done: pv=%b err=%b required pv=1 err=0", params_valid, err);
    end
    n_tests++;
    if (weights_flat !== exp_w() || biases_flat !== exp_b()) begin
      n_fail++;
      $display("FAIL gaps_image: got b=%h required b=%h", biases_flat, exp_b());
    end
    // The start pulse coincident with the final beat must not restart a load.
    @(negedge clk);
    n_tests++;
    if (params_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_start_ignored: pv=%b busy=%b required pv=1 busy=0", params_valid, busy);
    end
  endtask

  task automatic test_early_last();
    do_start();
    mk_beats(1'b0);
    send(41, 40, 1'b0, 1'b0);
    n_tests++;
    if ({err, params_valid, s_ready, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL early_last_flags: err/pv/rdy/busy=%b required 1000",
               {err, params_valid, s_ready, busy});
    end
    n_tests++;
    if (weights_flat !== exp_w() || biases_flat !== exp_b()) begin
      n_fail++;
      $display("FAIL early_last_image: got w=%h required w=%h",
               weights_flat[383:256], exp_w()[383:256]);
    end
    do_start();
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL early_last_restart: err=%b busy=%b required err=0 busy=1", err, busy);
    end
    mk_beats(1'b0);
    send(N_BEATS, N_BEATS-1, 1'b1, 1'b0);
`ifdef PARAM_CHECKSUM_EN
    @(posedge clk);
    #1;
`endif
    n_tests++;
    if (params_valid !== 1'b1 || err !== 1'b0 || weights_flat !== exp_w() || biases_flat !== exp_b()) begin
      n_fail++;
      $display("FAIL early_last_reload: pv=%b err=%b b=%h required pv=1 err=0 b=%h",
               params_valid, err, biases_flat, exp_b());
    end
  endtask

  task automatic test_missing_last();
    do_start();
    mk_beats(1'b0);
    beats[W_WORDS] = 8'hAA;
    send(N_BEATS, -1, 1'b0, 1'b0);
    n_tests++;
    if (err !== 1'b1 || params_valid !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL missing_last_flags: err=%b pv=%b rdy=%b required 1 0 0", err, params_valid, s_ready);
    end
    n_tests++;
    if (biases_flat[7:0] !== 8'hAA) begin
      n_fail++;
      $display("FAIL missing_last_bias0: got %h required aa", biases_flat[7:0]);
    end
    n_tests++;
    if (weights_flat !== exp_w() || biases_flat !== exp_b()) begin
      n_fail++;
      $display("FAIL missing_last_image: got b=%h required b=%h", biases_flat, exp_b());
    end
  endtask

  task automatic test_reset_mid_load();
    do_start();
    mk_beats(1'b0);
    send(31, -1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({s_ready, busy, params_valid, err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst30_flags: got %b required 0000", {s_ready, busy, params_valid, err});
    end
    n_tests++;
    if (weights_flat !== '0 || biases_flat !== '0) begin
      n_fail++;
      $display("FAIL rst30_flat: got w=%h b=%h required 0", weights_flat[255:0], biases_flat);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    mk_beats(1'b0);
    send(N_BEATS, N_BEATS-1, 1'b1, 1'b0);
`ifdef PARAM_CHECKSUM_EN
    @(posedge clk);
    #1;
`endif
    n_tests++;
    if (params_valid !== 1'b1 || weights_flat !== exp_w() || biases_flat !== exp_b()) begin
      n_fail++;
      $display("FAIL rst30_reload: pv=%b b=%h required pv=1 b=%h", params_valid, biases_flat, exp_b());
    end
  endtask

`ifdef PARAM_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    mk_beats(1'b1);
    send(N_BEATS, N_BEATS-1, 1'b0, 1'b0);
    n_tests++;
    if (params_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL csum_check_cycle: pv=%b busy=%b required pv=0 busy=1", params_valid, busy);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (params_valid !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_good: pv=%b err=%b required pv=1 err=0", params_valid, err);
    end
    do_start();
    mk_beats(1'b1);
    beats[T_WORDS] = beats[T_WORDS] + 8'd1;
    send(N_BEATS, N_BEATS-1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    n_tests++;
    if (err !== 1'b1 || params_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_bad: err=%b pv=%b required err=1 pv=0", err, params_valid);
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_ramp_load();
    test_gaps_and_start();
    test_early_last();
    test_missing_last();
    test_reset_mid_load();
`ifdef PARAM_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
